// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a receive FIFO, valid/ready output
// and sticky frame/parity/overrun flags.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 1084,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_async,
    input  logic                         i_rxd,
    output logic [DATA_BITS-1:0]         o_rx_data,
    output logic                         o_rx_valid,
    input  logic                         i_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
    output logic                         o_frame_err,
    output logic                         o_parity_err,
    output logic                         o_overrun,
    input  logic                         i_err_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

    state_t                 r_state;
    logic [1:0]             r_sync;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit;
    logic                   r_stop;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_frame_bad;
    logic                   r_par_bad;
    logic                   r_done;
    logic                   r_push;
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_level;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_overrun;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];

    logic w_rxs, w_tick, w_pop, w_full, w_good;

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_cnt == '0);
    assign w_pop  = o_rx_valid & i_rx_ready;
    assign w_full = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_good = r_done & ~r_frame_bad & ~r_par_bad;

    always_ff @(posedge i_clk or negedge i_reset_async) begin
        if (!i_reset_async) begin
            r_sync      <= 2'b11;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_stop      <= 1'b0;
            r_shift     <= '0;
            r_frame_bad <= 1'b0;
            r_par_bad   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            r_done <= 1'b0;
            r_cnt  <= w_tick ? FULL_CNT : r_cnt - 1'b1;
            case (r_state)
                IDLE: if (!w_rxs) begin
                    r_state     <= START;
                    r_cnt       <= HALF_CNT;
                    r_frame_bad <= 1'b0;
                    r_par_bad   <= 1'b0;
                end
                START: if (w_tick) begin
                    r_state <= w_rxs ? IDLE : DATA;
                    r_bit   <= '0;
                end
                DATA: if (w_tick) begin
                    r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                    r_bit   <= r_bit + 1'b1;
                    r_stop  <= 1'b0;
                    if (r_bit == LAST_BIT) r_state <= (PARITY != 0) ? PAR : STOP;
                end
                PAR: if (w_tick) begin
                    r_par_bad <= ((^r_shift) ^ w_rxs) != ODD;
                    r_state   <= STOP;
                end
                STOP: if (w_tick) begin
                    r_stop <= r_stop + 1'b1;
                    if (!w_rxs) r_frame_bad <= 1'b1;
                    if (r_stop == LAST_STOP) begin
                        r_done  <= 1'b1;
                        r_state <= (r_frame_bad || !w_rxs) ? BREAK : IDLE;
                    end
                end
                BREAK: if (w_rxs) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completion is decided one cycle after the last stop sample; the write lands a cycle later.
    always_ff @(posedge i_clk or negedge i_reset_async) begin
        if (!i_reset_async) begin
            r_push       <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_push       <= w_good & (~w_full | w_pop);
            r_frame_err  <= (r_frame_err & ~i_err_clr) | (r_done & r_frame_bad);
            r_parity_err <= (r_parity_err & ~i_err_clr) | (r_done & r_par_bad);
            r_overrun    <= (r_overrun & ~i_err_clr) | (w_good & w_full & ~w_pop);
            r_wptr       <= r_wptr + AW'(r_push);
            r_rptr       <= r_rptr + AW'(w_pop);
            r_level      <= r_level + (AW+1)'(r_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_push) r_mem[r_wptr] <= r_shift;
    end

    assign o_rx_valid   = (r_level != '0);
    assign o_rx_data    = o_rx_valid ? r_mem[r_rptr] : '0;
    assign o_fifo_level = r_level;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames into an 8N1 receiver and an 8E1 receiver;
// a negedge monitor pops expected words from per-instance queues on every handshake.
module tb_uart_rx_param;
    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic [2:0] lvl_a, lvl_b;
    logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

    int total = 0;
    int bad = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .i_clk(clk), .i_reset_async(rst_n), .i_rxd(rxd_a), .o_rx_data(data_a), .o_rx_valid(valid_a),
        .i_rx_ready(ready_a), .o_fifo_level(lvl_a), .o_frame_err(fe_a), .o_parity_err(pe_a),
        .o_overrun(ov_a), .i_err_clr(clr_a));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .i_clk(clk), .i_reset_async(rst_n), .i_rxd(rxd_b), .o_rx_data(data_b), .o_rx_valid(valid_b),
        .i_rx_ready(ready_b), .o_fifo_level(lvl_b), .o_frame_err(fe_b), .o_parity_err(pe_b),
        .o_overrun(ov_b), .i_err_clr(clr_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rxd_a = bits[i];
            else rxd_b = bits[i];
            step(CPB);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop, input logic good);
        if (good) q_a.push_back(d);
        drive(0, {2'b11, stop, d, 1'b0}, 10);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par, input logic good);
        if (good) q_b.push_back(d);
        drive(1, {2'b11, par, d, 1'b0}, 11);
    endtask

    task automatic drain(input int which);
        int k;
        k = 0;
        if (which == 0) begin
            ready_a = 1'b1;
            while (lvl_a != 0 && k < 40) begin step(1); k++; end
            ready_a = 1'b0;
            check("drain_a_level", lvl_a, 0);
        end else begin
            ready_b = 1'b1;
            while (lvl_b != 0 && k < 40) begin step(1); k++; end
            ready_b = 1'b0;
            check("drain_b_level", lvl_b, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_a actual=%0h required=no_word", data_a);
            end else check("pop_a", data_a, q_a.pop_front());
        end
        if (rst_n && valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_b actual=%0h required=no_word", data_b);
            end else check("pop_b", data_b, q_b.pop_front());
        end
    end

    initial begin
        logic [11:0] f;
        step(3);
        check("rst_hold_valid_a", valid_a, 0);
        check("rst_hold_level_a", lvl_a, 0);
        rst_n = 1'b1;
        step(5);
        check("rst_valid_a", valid_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_level_a", lvl_a, 0);
        check("rst_flags_a", {fe_a, pe_a, ov_a}, 0);
        check("rst_valid_b", valid_b, 0);
        check("rst_flags_b", {fe_b, pe_b, ov_b}, 0);

        send_a(8'h55, 1'b1, 1'b1);
        send_a(8'hA3, 1'b1, 1'b1);
        step(3);
        check("two_level", lvl_a, 2);
        check("two_head", data_a, 8'h55);
        ready_a = 1'b1;
        step(1);
        ready_a = 1'b0;
        check("after_pop_head", data_a, 8'hA3);
        check("after_pop_level", lvl_a, 1);
        drain(0);

        rxd_a = 1'b0;
        step(4);
        rxd_a = 1'b1;
        step(30);
        check("glitch_level", lvl_a, 0);
        check("glitch_flags", {fe_a, pe_a, ov_a}, 0);
        send_a(8'h3C, 1'b1, 1'b1);
        step(3);
        check("post_glitch_level", lvl_a, 1);
        check("post_glitch_data", data_a, 8'h3C);
        drain(0);

        send_a(8'h41, 1'b0, 1'b0);
        step(40);
        check("break_frame_err", fe_a, 1);
        check("break_level", lvl_a, 0);
        rxd_a = 1'b1;
        step(20);
        send_a(8'h42, 1'b1, 1'b1);
        step(3);
        check("post_break_level", lvl_a, 1);
        check("frame_err_sticky", fe_a, 1);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        check("frame_err_cleared", fe_a, 0);
        drain(0);

        send_b(8'h07, 1'b0, 1'b0);
        step(3);
        check("parity_err_set", pe_b, 1);
        check("parity_bad_level", lvl_b, 0);
        check("parity_no_frame_err", fe_b, 0);
        send_b(8'h07, 1'b1, 1'b1);
        step(3);
        check("parity_good_level", lvl_b, 1);
        check("parity_good_data", data_b, 8'h07);
        drain(1);

        for (int d = 1; d <= 5; d++) send_a(8'(d), 1'b1, d < 5);
        step(3);
        check("overrun_level", lvl_a, 4);
        check("overrun_flag", ov_a, 1);
        drain(0);
        check("overrun_empty_valid", valid_a, 0);

        send_a(8'h11, 1'b1, 1'b1);
        step(3);
        check("pre_reset_level", lvl_a, 1);
        f = {3'b111, 8'h99, 1'b0};
        drive(0, f, 4);
        rxd_a = f[4];
        step(6);
        rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        step(2);
        check("midrst_valid_a", valid_a, 0);
        check("midrst_data_a", data_a, 0);
        check("midrst_level_a", lvl_a, 0);
        check("midrst_flags_a", {fe_a, pe_a, ov_a}, 0);
        check("midrst_parity_b", pe_b, 0);
        rxd_a = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(5);
        send_a(8'h5A, 1'b1, 1'b1);
        step(3);
        check("post_rst_level", lvl_a, 1);
        check("post_rst_data", data_a, 8'h5A);
        drain(0);

        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
